nibbler_sequencer: RTL and testbench

//  Fetch/decode/execute controller of the Nibbler CPU, directly upstream of the ALU.
//  - Fetches 1- or 2-byte instructions from program ROM and drives the ALU mode lines (alu_s, alu_not_cin).
//  - Selects the ALU data_bus source and strobes accumulator, RAM and output-port writes.
//  - Consumes the ALU notC/notZ outputs: latches them into the flag register and uses them for conditional jumps.

---
 rtl/nibbler_pkg.sv | 48 ++++
 rtl/nibbler_decode.sv | 81 ++++++++
 rtl/nibbler_sequencer.sv | 153 +++++++++++++++
 tb/tb_nibbler_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
// Shared types and constants for the Nibbler fetch/decode/execute controller.
package nibbler_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADDI = 4'h1,
      OP_NORI = 4'h2,
      OP_LDI  = 4'h3,
      OP_ADDM = 4'h4,
      OP_NORM = 4'h5,
      OP_LDM  = 4'h6,
      OP_STM  = 4'h7,
      OP_JMP  = 4'h8,
      OP_JC   = 4'h9,
      OP_JNC  = 4'hA,
      OP_JZ   = 4'hB,
      OP_JNZ  = 4'hC,
      OP_OUT  = 4'hD,
      OP_IN   = 4'hE,
      OP_HALT = 4'hF
   } opcode_t;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      OPER  = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   // Jump condition codes; flags are active low.
   typedef enum logic [2:0] {
      COND_ALWAYS = 3'd0,
      COND_C      = 3'd1,
      COND_NC     = 3'd2,
      COND_Z      = 3'd3,
      COND_NZ     = 3'd4
   } cond_t;

   localparam logic [2:0] ALU_S_NONE = 3'b000;
   localparam logic [2:0] ALU_S_ADD  = 3'b011;
   localparam logic [2:0] ALU_S_NOR  = 3'b100;
   localparam logic [2:0] ALU_S_PASS = 3'b010;

   localparam logic [1:0] DBUS_IMM = 2'b00;
   localparam logic [1:0] DBUS_RAM = 2'b01;
   localparam logic [1:0] DBUS_IN  = 2'b10;

endpackage

// File: rtl/nibbler_decode.sv
// Combinational opcode decoder: maps ir[7:4] to the control word used in EXEC and FETCH.
import nibbler_pkg::*;

module nibbler_decode (
   input  logic [3:0] i_opcode,
   output logic [2:0] o_alu_s,
   output logic       o_alu_not_cin,
   output logic [1:0] o_dbus_sel,
   output logic       o_acc_load,
   output logic       o_ram_we,
   output logic       o_out_we,
   output logic       o_flag_en,
   output logic       o_two_byte,
   output logic       o_is_jump,
   output logic       o_is_halt,
   output logic [2:0] o_cond
);

   always_comb begin
      o_alu_s       = ALU_S_NONE;
      o_alu_not_cin = 1'b1;
      o_dbus_sel    = DBUS_IMM;
      o_acc_load    = 1'b0;
      o_ram_we      = 1'b0;
      o_out_we      = 1'b0;
      o_flag_en     = 1'b0;
      o_two_byte    = 1'b0;
      o_is_jump     = 1'b0;
      o_is_halt     = 1'b0;
      o_cond        = COND_ALWAYS;
      unique case (opcode_t'(i_opcode))
         OP_NOP: ;
         OP_ADDI, OP_ADDM: begin
            o_alu_s    = ALU_S_ADD;
            o_acc_load = 1'b1;
            o_flag_en  = 1'b1;
         end
         OP_NORI, OP_NORM: begin
            o_alu_s    = ALU_S_NOR;
            o_acc_load = 1'b1;
            o_flag_en  = 1'b1;
         end
         OP_LDI, OP_LDM: begin
            o_alu_s    = ALU_S_PASS;
            o_acc_load = 1'b1;
            o_flag_en  = 1'b1;
         end
         OP_STM:  o_ram_we = 1'b1;
         OP_JMP:  o_is_jump = 1'b1;
         OP_JC: begin
            o_is_jump = 1'b1;
            o_cond    = COND_C;
         end
         OP_JNC: begin
            o_is_jump = 1'b1;
            o_cond    = COND_NC;
         end
         OP_JZ: begin
            o_is_jump = 1'b1;
            o_cond    = COND_Z;
         end
         OP_JNZ: begin
            o_is_jump = 1'b1;
            o_cond    = COND_NZ;
         end
         OP_OUT:  o_out_we = 1'b1;
         OP_IN: begin
            o_alu_s    = ALU_S_PASS;
            o_dbus_sel = DBUS_IN;
            o_acc_load = 1'b1;
            o_flag_en  = 1'b1;
         end
         OP_HALT: o_is_halt = 1'b1;
      endcase

      // Opcodes 4..C carry an address-low operand byte.
      if (i_opcode >= OP_ADDM && i_opcode <= OP_JNZ) o_two_byte = 1'b1;
      if (i_opcode >= OP_ADDM && i_opcode <= OP_LDM) o_dbus_sel = DBUS_RAM;
   end

endmodule

// File: rtl/nibbler_sequencer.sv
// Nibbler CPU fetch/decode/execute controller. Optional single-step mode (step input)
// is enabled with the NIBBLER_SINGLE_STEP_EN macro.
import nibbler_pkg::*;

module nibbler_sequencer #(
   parameter int unsigned PC_W   = 12,
   parameter int unsigned DATA_W = 4
) (
   input  logic              clk,
   input  logic              reset,
`ifdef NIBBLER_SINGLE_STEP_EN
   input  logic              step,
`endif
   output logic [PC_W-1:0]   rom_addr,
   input  logic [7:0]        rom_data,
   output logic [2:0]        alu_s,
   output logic              alu_not_cin,
   output logic [1:0]        dbus_sel,
   output logic [DATA_W-1:0] imm,
   output logic [PC_W-1:0]   ram_addr,
   output logic              acc_load,
   output logic              ram_we,
   output logic              out_we,
   input  logic              alu_not_c,
   input  logic              alu_not_z,
   output logic              flag_not_c,
   output logic              flag_not_z,
   output logic              halted
);

   state_t          r_state, w_state_d;
   logic [PC_W-1:0] r_pc, w_pc_d;
   logic [7:0]      r_ir, w_ir_d;
   logic [7:0]      r_opnd, w_opnd_d;
   logic            r_flag_not_c, w_flag_not_c_d;
   logic            r_flag_not_z, w_flag_not_z_d;

   logic [3:0]      w_dec_op;
   logic [2:0]      w_alu_s;
   logic            w_alu_not_cin;
   logic [1:0]      w_dbus_sel;
   logic            w_acc_load, w_ram_we, w_out_we, w_flag_en;
   logic            w_two_byte, w_is_jump, w_is_halt;
   logic [2:0]      w_cond;
   logic            w_taken;
   logic            w_step;
   logic            w_exec;
   logic [PC_W-1:0] w_target;

`ifdef NIBBLER_SINGLE_STEP_EN
   assign w_step = step;
`else
   assign w_step = 1'b1;
`endif

   // In FETCH the decoder looks at the incoming byte to choose OPER vs EXEC.
   assign w_dec_op = (r_state == FETCH) ? rom_data[7:4] : r_ir[7:4];
   assign w_target = PC_W'({r_ir[DATA_W-1:0], r_opnd});

   nibbler_decode u_decode (
      .i_opcode      (w_dec_op),
      .o_alu_s       (w_alu_s),
      .o_alu_not_cin (w_alu_not_cin),
      .o_dbus_sel    (w_dbus_sel),
      .o_acc_load    (w_acc_load),
      .o_ram_we      (w_ram_we),
      .o_out_we      (w_out_we),
      .o_flag_en     (w_flag_en),
      .o_two_byte    (w_two_byte),
      .o_is_jump     (w_is_jump),
      .o_is_halt     (w_is_halt),
      .o_cond        (w_cond)
   );

   always_comb begin
      w_taken = 1'b0;
      case (cond_t'(w_cond))
         COND_ALWAYS: w_taken = 1'b1;
         COND_C:      w_taken = ~r_flag_not_c;
         COND_NC:     w_taken = r_flag_not_c;
         COND_Z:      w_taken = ~r_flag_not_z;
         COND_NZ:     w_taken = r_flag_not_z;
         default:     w_taken = 1'b0;
      endcase
   end

   always_comb begin
      w_state_d      = r_state;
      w_pc_d         = r_pc;
      w_ir_d         = r_ir;
      w_opnd_d       = r_opnd;
      w_flag_not_c_d = r_flag_not_c;
      w_flag_not_z_d = r_flag_not_z;
      unique case (r_state)
         FETCH: begin
            if (w_step) begin
               w_ir_d    = rom_data;
               w_pc_d    = r_pc + PC_W'(1);
               w_state_d = w_two_byte ? OPER : EXEC;
            end
         end
         OPER: begin
            w_opnd_d  = rom_data;
            w_pc_d    = r_pc + PC_W'(1);
            w_state_d = EXEC;
         end
         EXEC: begin
            if (w_flag_en) begin
               w_flag_not_c_d = alu_not_c;
               w_flag_not_z_d = alu_not_z;
            end
            if (w_is_jump && w_taken) w_pc_d = w_target;
            w_state_d = w_is_halt ? HALT : FETCH;
         end
         HALT: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= FETCH;
         r_pc         <= '0;
         r_ir         <= '0;
         r_opnd       <= '0;
         r_flag_not_c <= 1'b1;
         r_flag_not_z <= 1'b1;
      end else begin
         r_state      <= w_state_d;
         r_pc         <= w_pc_d;
         r_ir         <= w_ir_d;
         r_opnd       <= w_opnd_d;
         r_flag_not_c <= w_flag_not_c_d;
         r_flag_not_z <= w_flag_not_z_d;
      end
   end

   // Control lines are live only in EXEC; reset suppresses them immediately.
   assign w_exec      = (r_state == EXEC) && !reset;
   assign alu_s       = w_exec ? w_alu_s : 3'b000;
   assign alu_not_cin = w_exec ? w_alu_not_cin : 1'b0;
   assign dbus_sel    = w_exec ? w_dbus_sel : 2'b00;
   assign acc_load    = w_exec & w_acc_load;
   assign ram_we      = w_exec & w_ram_we;
   assign out_we      = w_exec & w_out_we;

   assign rom_addr    = r_pc;
   assign imm         = r_ir[DATA_W-1:0];
   assign ram_addr    = w_target;
   assign flag_not_c  = r_flag_not_c;
   assign flag_not_z  = r_flag_not_z;
   assign halted      = (r_state == HALT);

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Scoreboard bench for nibbler_sequencer: ROM + ALU/accumulator model, directed programs.
module tb_nibbler_sequencer;

   localparam logic [3:0] RAM_VAL = 4'hF;
   localparam logic [3:0] IN_VAL  = 4'h0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data;
   logic [2:0]  alu_s;
   logic        alu_not_cin;
   logic [1:0]  dbus_sel;
   logic [3:0]  imm;
   logic [11:0] ram_addr;
   logic        acc_load, ram_we, out_we;
   logic        alu_not_c, alu_not_z;
   logic        flag_not_c, flag_not_z, halted;
`ifdef NIBBLER_SINGLE_STEP_EN
   logic        step = 1'b1;
`endif

   logic [7:0]  rom [4096];
   logic [3:0]  acc;
   logic [3:0]  w_d, w_r;
   logic        w_c;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   typedef struct packed {
      logic        acc_load;
      logic        ram_we;
      logic        out_we;
      logic [2:0]  alu_s;
      logic        cin;
      logic [1:0]  dbus;
      logic [3:0]  imm;
      logic [11:0] ram_addr;
      logic        fc;
      logic        fz;
   } obs_t;

   obs_t exp_q[$];

   nibbler_sequencer dut (
      .clk         (clk),
      .reset       (reset),
`ifdef NIBBLER_SINGLE_STEP_EN
      .step        (step),
`endif
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .alu_s       (alu_s),
      .alu_not_cin (alu_not_cin),
      .dbus_sel    (dbus_sel),
      .imm         (imm),
      .ram_addr    (ram_addr),
      .acc_load    (acc_load),
      .ram_we      (ram_we),
      .out_we      (out_we),
      .alu_not_c   (alu_not_c),
      .alu_not_z   (alu_not_z),
      .flag_not_c  (flag_not_c),
      .flag_not_z  (flag_not_z),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   assign rom_data = rom[rom_addr];

   // ALU model: ADD with carry out, NOR, PASS; unknown modes give notC=notZ=0.
   always_comb begin
      case (dbus_sel)
         2'b01:   w_d = RAM_VAL;
         2'b10:   w_d = IN_VAL;
         default: w_d = imm;
      endcase
      w_r       = 4'h0;
      w_c       = 1'b0;
      alu_not_c = 1'b0;
      alu_not_z = 1'b0;
      case (alu_s)
         3'b011: begin
            {w_c, w_r} = {1'b0, acc} + {1'b0, w_d} + {4'b0000, ~alu_not_cin};
            alu_not_c  = ~w_c;
            alu_not_z  = |w_r;
         end
         3'b100: begin
            w_r       = ~(acc | w_d);
            alu_not_c = 1'b1;
            alu_not_z = |w_r;
         end
         3'b010: begin
            w_r       = w_d;
            alu_not_c = 1'b1;
            alu_not_z = |w_r;
         end
         default: ;
      endcase
   end

   always @(posedge clk) begin
      if (reset) acc <= 4'h0;
      else if (acc_load) acc <= w_r;
   end

   function automatic string fmt(input obs_t o);
      return $sformatf("ld=%0b we=%0b out=%0b s=%03b cin=%0b dbus=%02b imm=%h ra=%h fc=%0b fz=%0b",
                       o.acc_load, o.ram_we, o.out_we, o.alu_s, o.cin, o.dbus, o.imm,
                       o.ram_addr, o.fc, o.fz);
   endfunction

   // Monitor: every strobe cycle must match the next queued expectation.
   always @(negedge clk) begin : monitor
      obs_t got, e;
      if (acc_load || ram_we || out_we) begin
         got = '{acc_load, ram_we, out_we, alu_s, alu_not_cin, dbus_sel, imm, ram_addr,
                 flag_not_c, flag_not_z};
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_strobe got {%s} required no strobe", fmt(got));
         end else begin
            e = exp_q.pop_front();
            if (got === e) n_pass++;
            else $display("FAIL exec_word got {%s} required {%s}", fmt(got), fmt(e));
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %h required %h", name, got, exp);
   endtask

   task automatic push_exp(input logic ld, input logic we, input logic ow, input logic [2:0] s,
                           input logic [1:0] d, input logic [3:0] im, input logic [11:0] ra,
                           input logic fc, input logic fz);
      obs_t e;
      e = '{ld, we, ow, s, 1'b1, d, im, ra, fc, fz};
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      cyc += n;
   endtask

   // Enter reset and fill ROM with HALT; caller loads a program then calls go().
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
      @(negedge clk);
   endtask

   task automatic go();
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic run_to_halt(input string name, input int exp_cyc, input logic [11:0] exp_addr);
      while (!halted && cyc < 100) tick(1);
      chk({name, "_halt_cycle"}, cyc, exp_cyc);
      chk({name, "_halt_addr"}, {20'h0, rom_addr}, {20'h0, exp_addr});
   endtask

   task automatic chk_reset_state(input string name);
      chk(name, {rom_addr, imm, halted, acc_load, ram_we, out_we, alu_s, alu_not_cin, dbus_sel,
                 flag_not_c, flag_not_z},
          {12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 1'b1});
   endtask

   initial begin : stim
      logic ok;

      // Reset state, then LDI 1; ADDI 9; HALT.
      do_reset();
      chk_reset_state("reset_state");
      rom[0] = 8'h31; rom[1] = 8'h19; rom[2] = 8'hF0;
      push_exp(1, 0, 0, 3'b010, 2'b00, 4'h1, 12'h100, 1, 1);
      push_exp(1, 0, 0, 3'b011, 2'b00, 4'h9, 12'h900, 1, 1);
      go();
      run_to_halt("ldi_addi", 6, 12'h003);
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rom_addr != 12'h003 || !halted || acc_load || ram_we || out_we) ok = 1'b0;
      end
      chk("halt_hold", {31'h0, ok}, 32'h1);

      // JC taken: 8+9 carries.
      do_reset();
      rom[0] = 8'h38; rom[1] = 8'h19; rom[2] = 8'h90; rom[3] = 8'h40;
      rom[4] = 8'hD1; rom[12'h040] = 8'hF0;
      push_exp(1, 0, 0, 3'b010, 2'b00, 4'h8, 12'h800, 1, 1);
      push_exp(1, 0, 0, 3'b011, 2'b00, 4'h9, 12'h900, 1, 1);
      go();
      run_to_halt("jc_taken", 9, 12'h041);
      chk("jc_taken_flags", {30'h0, flag_not_c, flag_not_z}, 32'h1);

      // JC not taken: 1+9 has no carry.
      do_reset();
      rom[0] = 8'h31; rom[1] = 8'h19; rom[2] = 8'h90; rom[3] = 8'h40;
      rom[4] = 8'hF0; rom[12'h040] = 8'hD5;
      push_exp(1, 0, 0, 3'b010, 2'b00, 4'h1, 12'h100, 1, 1);
      push_exp(1, 0, 0, 3'b011, 2'b00, 4'h9, 12'h900, 1, 1);
      go();
      run_to_halt("jc_not_taken", 9, 12'h005);
      chk("jc_nt_flags", {30'h0, flag_not_c, flag_not_z}, 32'h3);

      // PC wrap: JMP 0xFFF, then a JMP at 0xFFF takes its operand from 0x000.
      do_reset();
      rom[0] = 8'h12; rom[1] = 8'h8F; rom[2] = 8'hFF; rom[3] = 8'hD3;
      rom[12'hFFF] = 8'h85; rom[12'h512] = 8'hF0;
      push_exp(1, 0, 0, 3'b011, 2'b00, 4'h2, 12'h200, 1, 1);
      go();
      tick(6);
      chk("wrap_oper_addr", {20'h0, rom_addr}, 32'h000);
      run_to_halt("wrap", 10, 12'h513);

      // STM after LDI 0: one RAM strobe, flags held at notC=1, notZ=0.
      do_reset();
      rom[0] = 8'h30; rom[1] = 8'h7A; rom[2] = 8'h34; rom[3] = 8'hF0;
      push_exp(1, 0, 0, 3'b010, 2'b00, 4'h0, 12'h000, 1, 1);
      push_exp(0, 1, 0, 3'b000, 2'b00, 4'hA, 12'hA34, 1, 0);
      go();
      run_to_halt("stm", 7, 12'h004);
      chk("stm_flags_held", {30'h0, flag_not_c, flag_not_z}, 32'h2);

      // Reset during OPER of a JMP.
      do_reset();
      rom[0] = 8'h38; rom[1] = 8'h18; rom[2] = 8'h85; rom[3] = 8'h55;
      push_exp(1, 0, 0, 3'b010, 2'b00, 4'h8, 12'h800, 1, 1);
      push_exp(1, 0, 0, 3'b011, 2'b00, 4'h8, 12'h800, 1, 1);
      go();
      tick(5);
      chk("pre_reset_flags", {30'h0, flag_not_c, flag_not_z}, 32'h0);
      reset = 1'b1;
      rom[0] = 8'hF0;
      tick(1);
      chk_reset_state("reset_in_oper");
      go();
      run_to_halt("after_reset", 2, 12'h001);

      // Reset raised during EXEC of LDI 0 suppresses the strobe.
      do_reset();
      rom[0] = 8'h30;
      go();
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("reset_wins_strobe", {31'h0, acc_load}, 32'h0);
      @(negedge clk);
      chk("reset_wins_flags", {19'h0, flag_not_z, rom_addr}, {19'h0, 1'b1, 12'h000});

      // NORI, OUT, IN, ADDM, JNZ taken.
      do_reset();
      rom[0] = 8'h2C; rom[1] = 8'hD7; rom[2] = 8'hE0; rom[3] = 8'h4A; rom[4] = 8'hBC;
      rom[5] = 8'hC0; rom[6] = 8'h20; rom[7] = 8'hD1; rom[12'h020] = 8'hF0;
      push_exp(1, 0, 0, 3'b100, 2'b00, 4'hC, 12'hC00, 1, 1);
      push_exp(0, 0, 1, 3'b000, 2'b00, 4'h7, 12'h700, 1, 1);
      push_exp(1, 0, 0, 3'b010, 2'b10, 4'h0, 12'h000, 1, 1);
      push_exp(1, 0, 0, 3'b011, 2'b01, 4'hA, 12'hABC, 1, 0);
      go();
      run_to_halt("mixed", 14, 12'h021);
      chk("mixed_acc", {28'h0, acc}, 32'hF);

      @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
